// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned samples into one ACC_WIDTH-bit result with a sticky
// carry flag, and hands the result downstream over a valid/ready handshake.
module sum_accumulator #(
  parameter int WIDTH     = 2,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic                 IN_clk,
  input  logic                 IN_rst_n,
  input  logic                 IN_clear,
  input  logic                 IN_sum_valid,
  input  logic [WIDTH-1:0]     IN_sum,
  output logic                 OUT_sum_ready,
  output logic                 OUT_acc_valid,
  output logic [ACC_WIDTH-1:0] OUT_acc,
  output logic                 OUT_ovf,
  input  logic                 IN_acc_ready
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 sum_ready_q, sum_ready_d;

  logic                 accept;
  logic                 result;
  logic [ACC_WIDTH:0]   sum_ext;

  assign accept  = IN_sum_valid & sum_ready_q;
  assign result  = IN_acc_ready & (state_q == DONE);
  // The extra top bit captures the carry out of the accumulator.
  assign sum_ext = {1'b0, acc_q} + (ACC_WIDTH + 1)'(IN_sum);

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (IN_clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          // Gate on accept so an undriven sample during idle cycles never
          // reaches the registers.
          if (accept) begin
            acc_d = sum_ext[ACC_WIDTH-1:0];
            ovf_d = ovf_q | sum_ext[ACC_WIDTH];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = DONE;
          end
        end
        DONE: begin
          if (result) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
    sum_ready_d = (state_d == ACCUM);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_ready_q <= sum_ready_d;
    end
  end

  assign OUT_sum_ready = sum_ready_q;
  assign OUT_acc_valid = (state_q == DONE);
  assign OUT_acc       = acc_q;
  assign OUT_ovf       = ovf_q;

endmodule
